fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the 8-deep x 32-bit fifo among NUM_REQ producers.
//  Each producer has its own valid/ready handshake. Grants are round-robin, with bounded bursts.
//  Drives fifo write_en/data_in and observes fifo full_fifo, which is active-low (0 = full).
//  Sits between producer blocks and the fifo write side; the read side is untouched.
// PARAMETERS
//  NUM_REQ    4   number of requesters, >=2 (need not be a power of 2)
//  DATA_W     32  data width, equal to fifo data width
//  MAX_BURST  4   max beats per grant before forced release, >=1
// PORTS
//  clk           in   1                 clock, all state on posedge
//  rst           in   1                 synchronous reset, active-high
//  req_valid     in   NUM_REQ           per-requester data valid
//  req_data      in   NUM_REQ*DATA_W    requester i data at [i*DATA_W +: DATA_W]
//  req_ready     out  NUM_REQ           per-requester accept (one-hot or 0)
//  fifo_full_n   in   1                 fifo full_fifo; 0 = full, 1 = space available
//  fifo_write_en out  1                 to fifo write_en
//  fifo_data_in  out  DATA_W            to fifo data_in
//  grant_valid   out  1                 1 while state==GRANT
//  grant_id      out  $clog2(NUM_REQ)   current/last granted requester index
//  wr_count      out  16                total accepted beats, wraps 0xFFFF->0
// BEHAVIOUR
//  Interface: one clock clk; reset rst is synchronous, active-high.
//  Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, wr_count=0.
//    Outputs are then req_ready=0, fifo_write_en=0, fifo_data_in=0, grant_valid=0.
//    rst takes priority over everything, including a beat in the same cycle (that beat is discarded).
//  State: 2-state FSM {IDLE, GRANT}.
//    Registers: rr_ptr and grant_id (both $clog2(NUM_REQ) bits); beat_cnt ($clog2(MAX_BURST+1) bits).
//  IDLE, if any req_valid: pick first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    Next cycle: state=GRANT, grant_id=i, beat_cnt=0.
//    No valid: stay IDLE. No beat is possible in IDLE (1-cycle arbitration latency).
//  GRANT, with g = grant_id:
//    beat = req_valid[g] & fifo_full_n.
//    req_ready[g] = fifo_full_n (combinational); all other ready bits = 0.
//    fifo_write_en = beat (combinational); fifo_data_in = req_data[g]. Zero-latency pass-through.
//  On each beat: wr_count+1 (mod 2^16), beat_cnt+1.
//  Release GRANT -> IDLE at the posedge when either:
//    (a) req_valid[g]=0, or
//    (b) a beat occurs with beat_cnt==MAX_BURST-1.
//    On release: rr_ptr=(g+1) mod NUM_REQ, beat_cnt=0. Exactly one idle cycle between grants.
//  Backpressure (fifo_full_n=0) in GRANT:
//    No beat, ready=0, write_en=0. Grant held indefinitely; beat_cnt and wr_count frozen.
//    (a) still applies.
//  Never writes when full: write_en is gated by fifo_full_n in the same cycle.
//  Producers hold data stable while valid=1 and ready=0. Dropping valid forfeits the grant.
//  grant_id keeps its last value in IDLE; grant_valid distinguishes.
//  Wrap: rr_ptr and the search index wrap NUM_REQ-1 -> 0 explicitly; no reliance on power-of-2 overflow.
// TESTING (NUM_REQ=4, MAX_BURST=4)
//  T1 reset: rst=1 for 2 cycles with req_valid=4'b1111
//    -> ready=0, write_en=0, grant_valid=0, wr_count=0 throughout; first grant after release is id 0.
//  T2 round-robin: all valid, full_n=1, distinct data per requester
//    -> grant order 0,1,2,3,0; 4 beats each, 1 idle cycle between grants.
//    -> wr_count=16 after 4 grants; fifo receives data in grant order.
//  T3 single requester: only req2 valid for 10 beats
//    -> bursts of 4,4,2, each separated by 1 idle cycle; the wrapping search re-selects 2 each time.
//    -> final rr_ptr=3, wr_count=10.
//  T4 full mid-burst: req1 does 2 beats, then full_n=0 for 5 cycles
//    -> write_en=0 and ready=0 for those 5 cycles; grant_id stays 1, beat_cnt stays 2.
//    -> after full_n=1, 2 more beats, then release.
//  T5 reset mid-burst: rst=1 during req3 beat 2, req0 and req3 valid
//    -> next cycle all outputs 0, wr_count=0; after rst drops, grant goes to req0.
//  T6 valid drop: req1 valid for 1 beat then 0, req0 valid throughout
//    -> release after the valid-low cycle, rr_ptr=2; next grant is req0 (search wraps 2,3,0).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of an 8x32 fifo.
// Grants are bounded to MAX_BURST beats; writes pass straight through while granted.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full_n,
  output logic                         fifo_write_en,
  output logic [DATA_W-1:0]            fifo_data_in,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [15:0]                  wr_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]    wr_cnt_q, wr_cnt_d;

  logic [DATA_W-1:0] data_a [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_a[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Search rr_ptr, rr_ptr+1, ... with an explicit wrap so any NUM_REQ works.
  logic           pick_ok;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] idx;

  always_comb begin
    pick_ok = 1'b0;
    pick_id = rr_ptr_q;
    idx     = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_ok && req_valid[idx]) begin
        pick_ok = 1'b1;
        pick_id = idx;
      end
      idx = (idx == LAST_ID) ? '0 : idx + IDW'(1);
    end
  end

  logic           granted;
  logic           cur_valid;
  logic           beat;
  logic           last_beat;
  logic [IDW-1:0] next_ptr;

  assign granted   = (state_q == GRANT);
  assign cur_valid = req_valid[gid_q];
  assign beat      = granted & cur_valid & fifo_full_n;
  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign next_ptr  = (gid_q == LAST_ID) ? '0 : gid_q + IDW'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gid_d      = gid_q;
    beat_cnt_d = beat_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d    = GRANT;
          gid_d      = pick_id;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (beat) begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
        // Dropping valid or finishing the burst hands the port on.
        if (!cur_valid || (beat && last_beat)) begin
          state_d    = IDLE;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gid_q      <= '0;
      beat_cnt_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gid_q      <= gid_d;
      beat_cnt_q <= beat_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  always_comb begin
    req_ready     = '0;
    fifo_write_en = beat;
    fifo_data_in  = '0;
    if (granted) begin
      req_ready[gid_q] = fifo_full_n;
      fifo_data_in     = data_a[gid_q];
    end
  end

  assign grant_valid = granted;
  assign grant_id    = gid_q;
  assign wr_count    = wr_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a beat scoreboard.
// Expected beats are queued by stimulus; a negedge monitor pops and compares.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   rv;
  logic [N-1:0]   ready;
  logic [N*W-1:0] rdata;
  logic           full_n;
  logic           we;
  logic [W-1:0]   din;
  logic           gv;
  logic [1:0]     gid;
  logic [15:0]    wc;

  int tests = 0;
  int fails = 0;
  int seq [N] = '{default: 0};

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ  (N),
    .DATA_W   (W),
    .MAX_BURST(MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (rv),
    .req_data     (rdata),
    .req_ready    (ready),
    .fifo_full_n  (full_n),
    .fifo_write_en(we),
    .fifo_data_in (din),
    .grant_valid  (gv),
    .grant_id     (gid),
    .wr_count     (wc)
  );

  function automatic logic [31:0] dval(int i, int s);
    return {8'(8'hA0 + i), 24'(s)};
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rdata[i*W +: W] = dval(i, seq[i]);
    end
  end

  // Producers advance their data only on an accepted beat.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst && rv[i] && ready[i]) seq[i] <= seq[i] + 1;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(int id, int s);
    q.push_back('{id: 2'(id), data: dval(id, s)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && we === 1'b1) begin
        chk("write_while_full", 32'(full_n), 32'd1);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got %h expected none", din);
        end else begin
          e = q.pop_front();
          chk("fifo_data", din, e.data);
          chk("beat_id", 32'(gid), 32'(e.id));
          chk("beat_ready", 32'(ready), 32'(4'b0001 << e.id));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [13:0] t3p;
    logic [9:0]  t4we;
    int          t4wc [10];
    logic        g;
    t3p  = 14'b01110111101111;
    t4we = 10'b0110000011;
    t4wc = '{0, 1, 2, 2, 2, 2, 2, 2, 3, 4};

    // T1: reset held two cycles with all requesters valid
    rst    = 1'b1;
    rv     = 4'b1111;
    full_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (i == 1) rst = 1'b0;
      neg();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_gv", 32'(gv), 32'd0);
      chk("rst_wc", 32'(wc), 32'd0);
      chk("rst_din", din, 32'd0);
    end

    // T2: round robin 0,1,2,3,0 with 4-beat bursts and one idle cycle
    for (int id = 0; id < 4; id++)
      for (int s = 0; s < 4; s++) push(id, s);
    for (int k = 0; k < 22; k++) begin
      step();
      if (k == 20) rv = 4'b0000;
      neg();
      g = (k == 20) ? 1'b1 : (k == 21) ? 1'b0 : (k % 5 != 4);
      chk("t2_gv", 32'(gv), 32'(g));
      if (g) chk("t2_gid", 32'(gid), (k == 20) ? 32'd0 : 32'(k / 5));
      if (k == 19) chk("t2_wc16", 32'(wc), 32'd16);
    end

    // T3: lone requester 2 gets bursts of 4,4,2
    step();
    rst = 1'b1;
    rv  = 4'b0000;
    neg();
    step();
    rst = 1'b0;
    rv  = 4'b0100;
    for (int s = 4; s < 14; s++) push(2, s);
    for (int k = 0; k < 14; k++) begin
      step();
      if (k == 12) rv = 4'b0000;
      if (k == 13) rv = 4'b1111;
      neg();
      chk("t3_gv", 32'(gv), 32'(t3p[k]));
      if (t3p[k]) chk("t3_gid", 32'(gid), 32'd2);
    end
    chk("t3_wc10", 32'(wc), 32'd10);
    step();
    rv  = 4'b0000;
    rst = 1'b1;
    neg();
    chk("t3_rr3_gv", 32'(gv), 32'd1);
    chk("t3_rr3_gid", 32'(gid), 32'd3);

    // T4: fifo full for 5 cycles in the middle of a req1 burst
    step();
    rst = 1'b0;
    rv  = 4'b0010;
    for (int s = 4; s < 8; s++) push(1, s);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 2) full_n = 1'b0;
      if (k == 7) full_n = 1'b1;
      if (k == 9) rv = 4'b0000;
      neg();
      chk("t4_gv", 32'(gv), (k != 9) ? 32'd1 : 32'd0);
      if (k != 9) chk("t4_gid", 32'(gid), 32'd1);
      chk("t4_we", 32'(we), 32'(t4we[k]));
      chk("t4_ready", 32'(ready), t4we[k] ? 32'd2 : 32'd0);
      chk("t4_wc", 32'(wc), 32'(t4wc[k]));
    end

    // T5: reset lands on req3's second beat
    push(3, 4);
    push(0, 4);
    push(1, 8);
    push(0, 5);
    step();
    rv = 4'b1001;
    neg();
    step();
    neg();
    chk("t5_gv", 32'(gv), 32'd1);
    chk("t5_gid3", 32'(gid), 32'd3);
    step();
    rst = 1'b1;
    neg();
    chk("t5_wc_pre", 32'(wc), 32'd5);
    step();
    rst = 1'b0;
    neg();
    chk("t5_gv0", 32'(gv), 32'd0);
    chk("t5_we0", 32'(we), 32'd0);
    chk("t5_ready0", 32'(ready), 32'd0);
    chk("t5_din0", din, 32'd0);
    chk("t5_wc0", 32'(wc), 32'd0);
    step();
    rv = 4'b0001;
    neg();
    chk("t5_regrant_gv", 32'(gv), 32'd1);
    chk("t5_regrant_gid0", 32'(gid), 32'd0);

    // T6: valid drop forfeits the grant and advances the pointer
    step();
    rv = 4'b0000;
    neg();
    chk("t6_hold_gv", 32'(gv), 32'd1);
    chk("t6_hold_we", 32'(we), 32'd0);
    step();
    rv = 4'b0011;
    neg();
    chk("t6_idle_a", 32'(gv), 32'd0);
    step();
    neg();
    chk("t6_gid1", 32'(gid), 32'd1);
    chk("t6_gv1", 32'(gv), 32'd1);
    step();
    rv = 4'b0001;
    neg();
    chk("t6_drop_gv", 32'(gv), 32'd1);
    chk("t6_drop_we", 32'(we), 32'd0);
    step();
    neg();
    chk("t6_idle_b", 32'(gv), 32'd0);
    step();
    neg();
    chk("t6_wrap_gv", 32'(gv), 32'd1);
    chk("t6_wrap_gid0", 32'(gid), 32'd0);
    step();
    rv = 4'b0000;
    neg();
    step();
    neg();
    chk("t6_end_gv", 32'(gv), 32'd0);
    chk("t6_wc3", 32'(wc), 32'd3);

    step();
    neg();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
